// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage: PC register, imem req/ack, instruction FIFO
//
// Purpose:
//   Owns the fetch PC and keeps at most one instruction-memory request
//   outstanding. Returned words are buffered in a small FIFO whose head is
//   presented to decode as {instr, pc, pc+4} with a valid/ready handshake.
//   A redirect reloads the fetch PC, flushes the FIFO and turns an
//   in-flight request into a discard.
//
// Parameters:
//   RESET_PC    fetch address loaded on reset
//   FIFO_DEPTH  instruction buffer entries (1..4)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   redirect_valid, redirect_pc   one-cycle redirect pulse and target
//   imem_req, imem_addr           registered memory request and word address
//   imem_ack, imem_rdata          memory completion and returned instruction
//   if_valid, if_ready            decode handshake
//   if_instr, if_pc, if_pc4       FIFO head contents
//   if_misalign                   head entry came from a misaligned PC
//                                 (only with IFETCH_ALIGN_CHECK_EN)
//
// Configuration macro:
//   IFETCH_ALIGN_CHECK_EN  misaligned fetch PCs push a marker entry and halt

module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
`ifdef IFETCH_ALIGN_CHECK_EN
    output logic        if_misalign,
`endif
    output logic [31:0] if_pc4
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
`ifdef IFETCH_ALIGN_CHECK_EN
        S_HALT    = 2'd3,
`endif
        S_DISCARD = 2'd2
    } state_t;

    localparam logic [2:0] DEPTH_C  = 3'(FIFO_DEPTH);
    localparam logic [1:0] LAST_PTR = 2'(FIFO_DEPTH - 1);

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] imem_addr_q, imem_addr_d;

    logic [2:0]  count_q, count_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [31:0] instr_q [4];
    logic [31:0] instr_d [4];
    logic [31:0] pc_q [4];
    logic [31:0] pc_d [4];
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        mis_q [4];
    logic        mis_d [4];
    logic        push_mis;
`endif

    logic        ack;
    logic        push;
    logic [31:0] push_instr;
    logic        pop;

    // An ack only means something while a request is actually on the bus.
    assign ack = imem_ack & imem_req_q;
    assign pop = if_ready & (count_q != 3'd0);

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
    endfunction

    // Fetch state machine
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        push        = 1'b0;
        push_instr  = 32'd0;
`ifdef IFETCH_ALIGN_CHECK_EN
        push_mis    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (redirect_valid) begin
                    // New target is requested on a later cycle.
                    fetch_pc_d = redirect_pc;
                end else if (count_q < DEPTH_C) begin
                    // Room is reserved at issue time, so the eventual push
                    // cannot overflow even if decode stalls meanwhile.
`ifdef IFETCH_ALIGN_CHECK_EN
                    if (fetch_pc_q[1:0] != 2'b00) begin
                        push     = 1'b1;
                        push_mis = 1'b1;
                        state_d  = S_HALT;
                    end else begin
`endif
                        imem_req_d  = 1'b1;
                        imem_addr_d = fetch_pc_q;
                        state_d     = S_BUSY;
`ifdef IFETCH_ALIGN_CHECK_EN
                    end
`endif
                end
            end
            S_BUSY: begin
                if (ack) begin
                    imem_req_d = 1'b0;
                    state_d    = S_IDLE;
                    if (redirect_valid) begin
                        fetch_pc_d = redirect_pc;
                    end else begin
                        push       = 1'b1;
                        push_instr = imem_rdata;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                end else if (redirect_valid) begin
                    // Request must stay stable on the bus; its data is dropped.
                    fetch_pc_d = redirect_pc;
                    state_d    = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                end
                if (ack) begin
                    imem_req_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
`ifdef IFETCH_ALIGN_CHECK_EN
            S_HALT: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Instruction FIFO
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        instr_d  = instr_q;
        pc_d     = pc_q;
`ifdef IFETCH_ALIGN_CHECK_EN
        mis_d    = mis_q;
`endif
        if (redirect_valid) begin
            // A head consumed this cycle still counts as delivered; everything
            // else is discarded.
            count_d  = 3'd0;
            rd_ptr_d = 2'd0;
            wr_ptr_d = 2'd0;
        end else begin
            if (push) begin
                instr_d[wr_ptr_q] = push_instr;
                pc_d[wr_ptr_q]    = fetch_pc_q;
`ifdef IFETCH_ALIGN_CHECK_EN
                mis_d[wr_ptr_q]   = push_mis;
`endif
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            count_d = count_q + {2'b00, push} - {2'b00, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            count_q     <= 3'd0;
            rd_ptr_q    <= 2'd0;
            wr_ptr_q    <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                instr_q[i] <= 32'd0;
                pc_q[i]    <= 32'd0;
`ifdef IFETCH_ALIGN_CHECK_EN
                mis_q[i]   <= 1'b0;
`endif
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
`ifdef IFETCH_ALIGN_CHECK_EN
            mis_q       <= mis_d;
`endif
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign if_valid  = (count_q != 3'd0);
    assign if_instr  = instr_q[rd_ptr_q];
    assign if_pc     = pc_q[rd_ptr_q];
    assign if_pc4    = if_pc + 32'd4;
`ifdef IFETCH_ALIGN_CHECK_EN
    assign if_misalign = mis_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        if_misalign;
`endif

    ifetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
`ifdef IFETCH_ALIGN_CHECK_EN
        .if_misalign    (if_misalign),
`endif
        .if_pc4         (if_pc4)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: every word at address a holds 32'h2000_0000 + a.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2000_0000 + a;
    endfunction

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
    } acc_t;

    acc_t        acc_q[$];
    logic [31:0] ack_q[$];

    int lat      = 0;
    int wait_cnt = 0;
    bit rand_lat = 0;

    // Memory responder: acks after `lat` waiting cycles.
    always @(negedge clk) begin
        if (imem_req && wait_cnt >= lat) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            wait_cnt = 0;
        end else if (imem_req && imem_ack) begin
            ack_q.push_back(imem_addr);
            wait_cnt = 0;
            if (rand_lat) lat = $urandom_range(0, 3);
        end else if (imem_req) begin
            wait_cnt++;
        end
    end

    // Reference model: decode must see a contiguous word stream starting at the
    // latest redirect target, each with instr = mem_word(pc).
    bit          model_en  = 0;
    logic [31:0] exp_pc    = 32'd0;
    bit          flush_chk = 0;
    bit          prev_busy = 0;
    logic [31:0] prev_addr = 32'd0;
    int          n_acc     = 0;

    always @(posedge clk) begin
        if (!rst && if_valid && if_ready) acc_q.push_back('{pc: if_pc, instr: if_instr, pc4: if_pc4});
        if (rst) begin
            prev_busy = 0;
            flush_chk = 0;
        end else if (model_en) begin
            if (flush_chk) check("rand_flush", {31'd0, if_valid}, 32'd0);
            flush_chk = 0;
            if (prev_busy) begin
                check("rand_req_hold", {31'd0, imem_req}, 32'd1);
                check("rand_addr_hold", imem_addr, prev_addr);
            end
            prev_busy = imem_req && !imem_ack;
            prev_addr = imem_addr;
            if (if_valid && if_ready) begin
                check("rand_pc", if_pc, exp_pc);
                check("rand_instr", if_instr, mem_word(exp_pc));
                check("rand_pc4", if_pc4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                n_acc++;
            end
            if (redirect_valid) begin
                exp_pc    = redirect_pc;
                flush_chk = 1;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0000_0000);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_instr", if_instr, 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_pc4", if_pc4, 32'd4);
        rst = 1'b0;
        acc_q.delete();
        ack_q.delete();
    endtask

    task automatic wait_acc(input int n);
        int b = 0;
        while (acc_q.size() < n && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (acc_q.size() < n) check("acc_timeout", 32'(acc_q.size()), 32'(n));
    endtask

    task automatic wait_req(input logic [31:0] addr);
        int b = 0;
        while (!(imem_req && imem_addr == addr) && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (!(imem_req && imem_addr == addr)) check("req_timeout", imem_addr, addr);
    endtask

    task automatic pulse_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    typedef struct packed {
        logic [31:0]      target;
        logic [2:0][31:0] pc;
        logic [2:0][31:0] instr;
        logic [2:0][31:0] pc4;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{target: 32'h0000_0100,
                    pc:    {32'h0000_0108, 32'h0000_0104, 32'h0000_0100},
                    instr: {32'h2000_0108, 32'h2000_0104, 32'h2000_0100},
                    pc4:   {32'h0000_010C, 32'h0000_0108, 32'h0000_0104}};
        vecs[1] = '{target: 32'hFFFF_FFF8,
                    pc:    {32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFF8},
                    instr: {32'h2000_0000, 32'h1FFF_FFFC, 32'h1FFF_FFF8},
                    pc4:   {32'h0000_0004, 32'h0000_0000, 32'hFFFF_FFFC}};
        vecs[2] = '{target: 32'h0000_1230,
                    pc:    {32'h0000_1238, 32'h0000_1234, 32'h0000_1230},
                    instr: {32'h2000_1238, 32'h2000_1234, 32'h2000_1230},
                    pc4:   {32'h0000_123C, 32'h0000_1238, 32'h0000_1234}};
        vecs[3] = '{target: 32'h7FFF_FFFC,
                    pc:    {32'h8000_0004, 32'h8000_0000, 32'h7FFF_FFFC},
                    instr: {32'hA000_0004, 32'hA000_0000, 32'h9FFF_FFFC},
                    pc4:   {32'h8000_0008, 32'h8000_0004, 32'h8000_0000}};

        // Basic stream with single-cycle ack.
        lat = 0;
        do_reset();
        if_ready = 1'b1;
        wait_acc(3);
        for (int i = 0; i < 3; i++) check("basic_addr", ack_q[i], 32'(4 * i));
        for (int i = 0; i < 2; i++) begin
            check("basic_pc", acc_q[i].pc, 32'(4 * i));
            check("basic_instr", acc_q[i].instr, 32'h2000_0000 + 32'(4 * i));
            check("basic_pc4", acc_q[i].pc4, 32'(4 * i + 4));
        end

        // Table: redirect targets including PC wrap.
        foreach (vecs[v]) begin
            @(negedge clk);
            pulse_redirect(vecs[v].target);
            acc_q.delete();
            wait_acc(3);
            for (int i = 0; i < 3; i++) begin
                check("tbl_pc", acc_q[i].pc, vecs[v].pc[i]);
                check("tbl_instr", acc_q[i].instr, vecs[v].instr[i]);
                check("tbl_pc4", acc_q[i].pc4, vecs[v].pc4[i]);
            end
        end

        // Backpressure: FIFO fills to 2 entries and fetching stops.
        if_ready = 1'b0;
        do_reset();
        repeat (12) @(negedge clk);
        check("bp_req_off", {31'd0, imem_req}, 32'd0);
        check("bp_acks", 32'(ack_q.size()), 32'd2);
        check("bp_valid", {31'd0, if_valid}, 32'd1);
        check("bp_head_pc", if_pc, 32'd0);
        check("bp_head_instr", if_instr, 32'h2000_0000);
        if_ready = 1'b1;
        wait_acc(3);
        for (int i = 0; i < 3; i++) check("bp_order", acc_q[i].pc, 32'(4 * i));

        // Redirect while a slow request is pending, with an entry buffered.
        if_ready = 1'b0;
        lat = 3;
        do_reset();
        wait_req(32'h4);
        check("rd_pre_valid", {31'd0, if_valid}, 32'd1);
        pulse_redirect(32'h0000_0100);
        check("rd_flush", {31'd0, if_valid}, 32'd0);
        check("rd_req_hold", {31'd0, imem_req}, 32'd1);
        check("rd_addr_hold", imem_addr, 32'h4);
        ack_q.delete();
        acc_q.delete();
        if_ready = 1'b1;
        wait_acc(1);
        check("rd_first_pc", acc_q[0].pc, 32'h0000_0100);
        check("rd_ack0", ack_q[0], 32'h4);
        check("rd_ack1", ack_q[1], 32'h0000_0100);

        // Redirect coincident with ack: acked word is dropped.
        lat = 0;
        do_reset();
        wait_req(32'h4);
        pulse_redirect(32'h0000_0300);
        acc_q.delete();
        ack_q.delete();
        wait_acc(1);
        check("ra_first_pc", acc_q[0].pc, 32'h0000_0300);
        check("ra_first_instr", acc_q[0].instr, 32'h2000_0300);
        check("ra_next_addr", ack_q[0], 32'h0000_0300);

        // Reset during an outstanding request.
        lat = 3;
        wait_req(32'h0000_0308);
        rst = 1'b1;
        @(negedge clk);
        check("rb_req", {31'd0, imem_req}, 32'd0);
        check("rb_valid", {31'd0, if_valid}, 32'd0);
        check("rb_addr", imem_addr, 32'h0);
        rst = 1'b0;
        acc_q.delete();
        ack_q.delete();
        wait_acc(1);
        check("rb_resume_pc", acc_q[0].pc, 32'h0);

`ifdef IFETCH_ALIGN_CHECK_EN
        // Misaligned target halts fetch after a marker entry.
        lat = 0;
        if_ready = 1'b0;
        do_reset();
        pulse_redirect(32'h0000_0102);
        ack_q.delete();
        repeat (6) @(negedge clk);
        check("ma_req", {31'd0, imem_req}, 32'd0);
        check("ma_valid", {31'd0, if_valid}, 32'd1);
        check("ma_flag", {31'd0, if_misalign}, 32'd1);
        check("ma_pc", if_pc, 32'h0000_0102);
        check("ma_instr", if_instr, 32'd0);
        if_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("ma_halted", {31'd0, if_valid | imem_req}, 32'd0);
        check("ma_no_ack", 32'(ack_q.size()), 32'd0);
        pulse_redirect(32'h0000_0200);
        acc_q.delete();
        wait_acc(1);
        check("ma_resume", acc_q[0].pc, 32'h0000_0200);
`endif

        // Randomized run against the stream model.
        lat = 1;
        rand_lat = 1;
        do_reset();
        exp_pc = 32'h0;
        n_acc = 0;
        model_en = 1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if_ready       = ($urandom % 4) != 0;
            redirect_valid = ($urandom % 40) == 0;
            redirect_pc    = (($urandom % 4) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        model_en = 0;
        check("rand_liveness", {31'd0, n_acc > 200}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch stage at the front of the pipeline.
- Owns the architectural PC register and issues word requests to instruction memory through a req/ack handshake.
- Buffers returned instructions in a small FIFO, then presents {instr, pc, pc+4} to decode through a valid/ready handshake.
- Accepts redirects (branch / jump / jr targets) from the next-PC logic; a redirect flushes queued and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries. Legal values are 1..4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- redirect_valid  input  1  one-cycle pulse; load redirect_pc as the next fetch address.
- redirect_pc  input  32  new fetch address.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  word address of the request.
- imem_ack  input  1  request completed; imem_rdata is valid this cycle.
- imem_rdata  input  32  instruction word.
- if_valid  output  1  FIFO head is valid.
- if_ready  input  1  decode accepts the head this cycle.
- if_instr  output  32  head instruction.
- if_pc  output  32  head PC.
- if_pc4  output  32  head PC + 4.

Behaviour:
- Reset (rst=1 at a clock edge):
  - fetch_pc = RESET_PC.
  - FIFO empties; count = 0.
  - State = IDLE.
  - imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc4=4.
  - Reset overrides every other input, including a concurrent ack or redirect.
- State machine (tracks at most one outstanding memory request):
  - IDLE: if count < FIFO_DEPTH and redirect_valid=0, assert imem_req with imem_addr=fetch_pc and go to BUSY. The request is visible from the next cycle: imem_req and imem_addr are registered outputs.
  - BUSY: imem_req=1 and imem_addr stay stable until imem_ack.
    - On ack with no redirect: push {imem_rdata, fetch_pc}, set fetch_pc += 4, go to IDLE.
  - DISCARD: imem_req stays high with the old address until ack. On ack, drop the data and go to IDLE. No push.
- Request-before-room rule: a request is issued only if count < FIFO_DEPTH at issue time, so a push can never overflow.
- imem_ack is ignored while imem_req=0.
- Redirect (redirect_valid=1):
  - fetch_pc <= redirect_pc.
  - FIFO flushed (count=0, if_valid=0 next cycle).
  - BUSY moves to DISCARD. IDLE stays IDLE; the new request issues no earlier than the following cycle. DISCARD stays DISCARD.
  - Redirect and ack in the same cycle: the ack data is dropped and the state goes to IDLE with fetch_pc=redirect_pc.
  - Redirect and if_ready in the same cycle: the head is consumed (the decode handshake completes) and the flush still happens.
- FIFO:
  - Head outputs are driven directly from storage; zero added latency from push to if_valid on the next edge.
  - Push and pop in the same cycle when full is legal; count is unchanged.
  - Pop on empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Arithmetic:
  - fetch_pc + 4 and if_pc4 wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
  - imem_addr[1:0] is always driven from fetch_pc[1:0] unaltered.
- Throughput: one instruction per two cycles with single-cycle ack (issue, ack). Back-to-back issue in the ack cycle is not permitted.

Optional Feature:
- Macro: IFETCH_ALIGN_CHECK_EN.
- When defined:
  - Extra output if_misalign (1 bit, travels with each FIFO entry).
  - If fetch_pc[1:0] != 0 when IDLE would issue, no memory request is made. Instead an entry {instr=0, pc=fetch_pc, misalign=1} is pushed and the unit enters HALT.
  - HALT issues nothing until redirect or reset.
  - if_misalign resets to 0.
- When undefined: no if_misalign port, no HALT state, and misaligned addresses are fetched like any other.

Test Plan:
- Reset, then imem_ack returned 1 cycle after each req with rdata = 32'h2000_0000 + addr, if_ready=1 -> imem_addr sequence 0,4,8. Decode sees (pc 0, instr 32'h2000_0000), (4, 32'h2000_0004) with if_pc4 = pc+4.
- if_ready=0 for 10 cycles with FIFO_DEPTH=2 -> exactly two entries (pc 0, 4) held, imem_req stays 0 afterwards, no overflow. Releasing if_ready delivers pc 0, 4, 8 in order.
- Redirect to 32'h0000_0100 while a request to 8 is pending (ack 3 cycles later) -> imem_addr holds 8 until ack, data dropped, next request at 0x100, first if_pc = 0x100, FIFO flushed the cycle after the redirect.
- redirect_valid and imem_ack in the same cycle -> acked word never appears on if_instr; next imem_addr = redirect_pc.
- fetch_pc = 32'hFFFF_FFFC, ack -> pushed if_pc4 = 0, next imem_addr = 0. Assert rst mid-BUSY -> imem_req=0 and if_valid=0 next cycle, fetch resumes at RESET_PC.
- With IFETCH_ALIGN_CHECK_EN, redirect to 32'h0000_0102 -> no imem_req, if_valid=1 with if_misalign=1 and if_pc=0x102, then nothing further until redirect to 0x200 resumes normal fetch.
